// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// W iterations per operation, results land in HI/LO on the RUN->DONE edge.
module mul_div_unit #(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  input  logic [1:0]   mdop,
  input  logic [W-1:0] porta,
  input  logic [W-1:0] portb,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         divzero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            div_q, sa_q, sb_q, dz_q;
  logic [W-1:0]    opd, hi_q, lo_q;
  logic [2*W-1:0]  acc;

  logic            accept, dz, issue, last;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  // a START is only looked at outside RUN, and FLUSH drops it outright
  assign accept = (state != S_RUN) && start && !flush;
  assign dz     = accept && mdop[1] && (portb == '0);
  assign issue  = accept && !dz;
  assign last   = (state == S_RUN) && !flush && (cnt == '0);

  assign a_neg  = ~mdop[0] & porta[W-1];
  assign b_neg  = ~mdop[0] & portb[W-1];
  assign a_mag  = a_neg ? -porta : porta;
  assign b_mag  = b_neg ? -portb : portb;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = issue ? S_RUN : S_IDLE;
      S_RUN: begin
        if (flush)            state_nxt = S_IDLE;
        else if (cnt == '0)   state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  logic [W:0]     mul_sum, div_sh, div_tr;
  logic           div_ok;
  logic [2*W-1:0] mul_nxt, div_nxt, step, prod_fin;
  logic [W-1:0]   hi_fin, lo_fin;

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
    mul_nxt = {mul_sum, acc[W-1:1]};
    div_sh  = {acc[2*W-1:W], acc[W-1]};
    div_tr  = div_sh - {1'b0, opd};
    div_ok  = ~div_tr[W];
    div_nxt = {(div_ok ? div_tr[W-1:0] : div_sh[W-1:0]), acc[W-2:0], div_ok};
    step    = div_q ? div_nxt : mul_nxt;
    prod_fin = (sa_q ^ sb_q) ? -step : step;
    if (div_q) begin
      lo_fin = (sa_q ^ sb_q) ? -step[W-1:0] : step[W-1:0];
      hi_fin = sa_q ? -step[2*W-1:W] : step[2*W-1:W];
    end else begin
      lo_fin = prod_fin[W-1:0];
      hi_fin = prod_fin[2*W-1:W];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= '0;
      div_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      opd   <= '0;
      acc   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      dz_q <= dz;
      if (issue) begin
        cnt   <= CW'(W-1);
        div_q <= mdop[1];
        sa_q  <= a_neg;
        sb_q  <= b_neg;
        opd   <= b_mag;
        acc   <= {{W{1'b0}}, a_mag};
      end else if (state == S_RUN) begin
        acc <= step;
        cnt <= cnt - 1'b1;
      end
      if (last) begin
        hi_q <= hi_fin;
        lo_q <= lo_fin;
      end
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign divzero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic reference model plus a per-cycle
// output compare, with literal expectations from hand-worked vectors.
module tb_mul_div_unit;
  localparam int W = 32;

  logic          clk = 0, nrst = 0, start = 0, flush = 0;
  logic [1:0]    mdop = 0;
  logic [W-1:0]  porta = 0, portb = 0;
  logic          busy, done, divzero;
  logic [W-1:0]  hi, lo;

  int checks = 0, errors = 0;

  mul_div_unit #(.W(W), .CW(5)) dut (
    .clk(clk), .nrst(nrst), .start(start), .mdop(mdop), .porta(porta),
    .portb(portb), .flush(flush), .busy(busy), .done(done),
    .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = ua * ub;
      2'd2: begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      default: p = {32'(ua % ub), 32'(ua / ub)};
    endcase
    return p;
  endfunction

  // Schedule model: W busy cycles after an accepted issue, then a one-cycle done with new HI/LO
  int           m_left;
  logic         exp_busy, exp_done, exp_dz;
  logic [W-1:0] exp_hi, exp_lo, pend_hi, pend_lo;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_left <= 0; exp_busy <= 0; exp_done <= 0; exp_dz <= 0;
      exp_hi <= 0; exp_lo <= 0; pend_hi <= 0; pend_lo <= 0;
    end else begin
      exp_done <= 0;
      exp_dz   <= 0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0; exp_busy <= 0;
        end else if (m_left == 1) begin
          m_left <= 0; exp_busy <= 0; exp_done <= 1;
          exp_hi <= pend_hi; exp_lo <= pend_lo;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start && !flush) begin
        if (mdop[1] && portb == 0) begin
          exp_dz <= 1;
        end else begin
          m_left <= W; exp_busy <= 1;
          {pend_hi, pend_lo} <= ref_calc(mdop, porta, portb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("divzero", 32'(divzero), 32'(exp_dz));
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  // Called at posedge+1; start is sampled on the following edge
  task automatic issue_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1; mdop = op; porta = a; portb = b;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Waits for done (bounded), counting busy cycles; returns at the negedge of the done cycle
  task automatic wait_done(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    int n, nb;
    n = 0; nb = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      if (busy) nb++;
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 100), 32'd1);
    chk({name, "_busycyc"}, 32'(nb), 32'd32);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    @(posedge clk); #1;
    issue_op(op, a, b);
    wait_done(name, ehi, elo);
  endtask

  initial begin
    int ndone;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk); nrst = 1;

    // model anchors against hand-worked values
    chk("ref_mult", ref_calc(2'd0, 32'hFFFFFFFD, 32'd7) >> 32, 32'hFFFFFFFF);
    chk("ref_div", 32'(ref_calc(2'd2, 32'hFFFFFFF9, 32'd2)), 32'hFFFFFFFD);

    run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_min", 2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("mult_m3x7", 2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_m7d2", 2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100d7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_7dm2", 2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("preload", 2'd3, 32'h02469234, 32'h2000, 32'h1234, 32'h1234);

    // divide by zero: pulse, no busy, HI/LO untouched
    @(posedge clk); #1;
    issue_op(2'd2, 32'd5, 32'd0);
    @(negedge clk);
    chk("dz_pulse", 32'(divzero), 1);
    chk("dz_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("dz_pulse_end", 32'(divzero), 0);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'h1234);

    // flush and start in the same idle cycle: start dropped
    @(posedge clk); #1;
    start = 1; flush = 1; mdop = 2'd1; porta = 3; portb = 4;
    @(posedge clk); #1;
    start = 0; flush = 0;
    @(negedge clk);
    chk("flush_start_busy", 32'(busy), 0);

    // start ignored in RUN, then flush at cycle 10
    @(posedge clk); #1;
    issue_op(2'd1, 32'd5, 32'd6);
    @(posedge clk); #1;
    start = 1; mdop = 2'd3; porta = 9; portb = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_nodone", 32'(ndone), 0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h1234);

    // back-to-back: second START held in the DONE cycle
    run_op("b2b_a", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15);
    start = 1; mdop = 2'd3; porta = 32'd1000; portb = 32'd33;
    @(posedge clk); #1;
    start = 0;
    wait_done("b2b_b", 32'd10, 32'd30);

    // asynchronous reset mid-RUN
    @(posedge clk); #1;
    issue_op(2'd1, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #3 nrst = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_dz", 32'(divzero), 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    #2 nrst = 1;
    repeat (40) @(negedge clk);
    chk("arst_stays_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
